// File: rtl/wisc_pkg.sv
// Shared types for the 16x16 register file and its write-port scheduler.
package wisc_pkg;
  localparam int NUM_REGS = 16;
  localparam int MAX_LAT  = 3;

  typedef logic [3:0] reg_id_t;

  typedef struct packed {
    logic    valid;
    reg_id_t dst;
  } slot_t;

  function automatic logic [NUM_REGS-1:0] decodeReg(input reg_id_t r);
    return NUM_REGS'(1) << r;
  endfunction
endpackage

// File: rtl/wb_slot_queue.sv
// Writeback slot shift register: slot[1] retires this cycle, slot[k] retires k-1 cycles later.
module wb_slot_queue
  import wisc_pkg::*;
#(
  parameter int DEPTH = MAX_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               fillEn,
  input  logic [1:0]         fillLat,
  input  reg_id_t            fillDst,
  output logic [DEPTH:1]     slotValid,
  output reg_id_t [DEPTH:1]  slotDst
);

  slot_t slots [1:DEPTH];
  logic [DEPTH+1:1] validPad;

  // The fill lands after the shift, so it targets the slot that retires fillLat cycles from now.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= DEPTH; k++) slots[k] <= '0;
    end else if (flush) begin
      for (int k = 1; k <= DEPTH; k++) slots[k] <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) slots[k] <= slots[k+1];
      slots[DEPTH] <= '0;
      if (fillEn) slots[fillLat] <= {1'b1, fillDst};
    end
  end

  always_comb begin
    slotValid = '0;
    slotDst   = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      slotValid[k] = slots[k].valid;
      slotDst[k]   = slots[k].dst;
    end
  end

  assign validPad = {1'b0, slotValid};

  fillLatLegal: assert property (@(posedge clk) disable iff (!rst)
    fillEn |-> (fillLat != 2'd0));

  noSlotCollision: assert property (@(posedge clk) disable iff (!rst)
    (fillEn && !flush && (32'(fillLat) < DEPTH)) |-> !validPad[3'(fillLat) + 3'd1]);

endmodule

// File: rtl/rf_write_scheduler.sv
// Register-file write scheduler: hazard stalls, write-port slot booking, retire strobes.
// Optional RF_BYPASS_EN: slot[1] forwards to read ports, so it is excluded from RAW and fwd1/fwd2 appear.
module rf_write_scheduler
  import wisc_pkg::*;
#(
  parameter int MAX_LAT = wisc_pkg::MAX_LAT,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  reg_id_t             issue_src1,
  input  reg_id_t             issue_src2,
  input  logic                issue_wr,
  input  reg_id_t             issue_dst,
  input  logic [1:0]          issue_lat,
  input  logic                flush,
  output logic                issue_stall,
  output logic                rf_wr_en,
  output reg_id_t             rf_wr_dst,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    stall_cnt
`ifdef RF_BYPASS_EN
  ,
  output logic                fwd1,
  output logic                fwd2
`endif
);

`ifdef RF_BYPASS_EN
  localparam int RAW_FIRST = 2;
`else
  localparam int RAW_FIRST = 1;
`endif

  logic [MAX_LAT:1]    slotValid;
  reg_id_t [MAX_LAT:1] slotDst;
  logic [MAX_LAT+1:1]  validPad;
  logic [1:0]          effLat;
  logic [NUM_REGS-1:0] busyAll;
  logic [NUM_REGS-1:0] rawBusy;
  logic                raw;
  logic                waw;
  logic                portHit;
  logic                fillEn;

  assign effLat   = (issue_lat == 2'd0) ? 2'd1 : issue_lat;
  assign validPad = {1'b0, slotValid};

  always_comb begin
    busyAll = '0;
    rawBusy = '0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (slotValid[k]) begin
        busyAll = busyAll | decodeReg(slotDst[k]);
        if (k >= RAW_FIRST) rawBusy = rawBusy | decodeReg(slotDst[k]);
      end
    end
    busyAll[0] = 1'b0;
    rawBusy[0] = 1'b0;
  end

  // Handshake: an instruction with issue_valid is consumed at the rising edge where issue_stall
  // is low; while issue_stall is high decode holds it and nothing is booked.
  assign raw     = ((issue_src1 != '0) && rawBusy[issue_src1]) ||
                   ((issue_src2 != '0) && rawBusy[issue_src2]);
  assign waw     = issue_wr && (issue_dst != '0) && busyAll[issue_dst];
  assign portHit = issue_wr && (issue_dst != '0) && (32'(effLat) < MAX_LAT) &&
                   validPad[3'(effLat) + 3'd1];

  assign issue_stall = issue_valid && (raw || waw || portHit);
  assign fillEn      = issue_valid && !issue_stall && issue_wr && (issue_dst != '0);

  wb_slot_queue #(.DEPTH(MAX_LAT)) uQueue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fillEn    (fillEn),
    .fillLat   (effLat),
    .fillDst   (issue_dst),
    .slotValid (slotValid),
    .slotDst   (slotDst)
  );

  assign rf_wr_en  = slotValid[1];
  assign rf_wr_dst = slotDst[1];
  assign busy_mask = busyAll;

`ifdef RF_BYPASS_EN
  assign fwd1 = slotValid[1] && (slotDst[1] == issue_src1) && (issue_src1 != '0);
  assign fwd2 = slotValid[1] && (slotDst[1] == issue_src2) && (issue_src2 != '0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (issue_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  latNonZero: assert property (@(posedge clk) disable iff (!rst)
    issue_valid |-> (issue_lat != 2'd0));

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: scoreboard of expected retire cycles and stall tracking.
module tb_rf_write_scheduler;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk;
  logic             rst;
  logic             issue_valid;
  logic [3:0]       issue_src1;
  logic [3:0]       issue_src2;
  logic             issue_wr;
  logic [3:0]       issue_dst;
  logic [1:0]       issue_lat;
  logic             flush;
  logic             issue_stall;
  logic             rf_wr_en;
  logic [3:0]       rf_wr_dst;
  logic [15:0]      busy_mask;
  logic [CNT_W-1:0] stall_cnt;
`ifdef RF_BYPASS_EN
  logic             fwd1;
  logic             fwd2;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [CNT_W-1:0] expCnt = '0;
  // {due cycle, dst}
  logic [35:0] exp_q[$];

  rf_write_scheduler #(.MAX_LAT(3), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_src1  (issue_src1),
    .issue_src2  (issue_src2),
    .issue_wr    (issue_wr),
    .issue_dst   (issue_dst),
    .issue_lat   (issue_lat),
    .flush       (flush),
    .issue_stall (issue_stall),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_dst   (rf_wr_dst),
    .busy_mask   (busy_mask),
    .stall_cnt   (stall_cnt)
`ifdef RF_BYPASS_EN
    ,
    .fwd1        (fwd1),
    .fwd2        (fwd2)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic w, input logic [3:0] d, input logic [1:0] l);
    issue_valid = v;
    issue_src1  = s1;
    issue_src2  = s2;
    issue_wr    = w;
    issue_dst   = d;
    issue_lat   = l;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 2'd1);
  endtask

  // Scoreboard: the write port must show exactly the entry due this cycle
  task automatic chkWritePort();
    int hit;
    hit = -1;
    foreach (exp_q[i]) if (int'(exp_q[i][35:4]) == cyc) hit = i;
    chk("rf_wr_en", 32'(rf_wr_en), 32'(hit >= 0));
    if (hit >= 0) begin
      chk("rf_wr_dst", 32'(rf_wr_dst), 32'(exp_q[hit][3:0]));
      exp_q.delete(hit);
    end
  endtask

  task automatic step(input logic expStall);
    @(negedge clk);
    chkWritePort();
    chk("issue_stall", 32'(issue_stall), 32'(expStall));
    if (expStall && expCnt != CNT_MAX) expCnt++;
    if (issue_valid && !expStall && issue_wr && issue_dst != 4'd0 && !flush)
      exp_q.push_back({32'(cyc + int'(issue_lat)), issue_dst});
    if (flush)
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (int'(exp_q[i][35:4]) > cyc) exp_q.delete(i);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wr_en", 32'(rf_wr_en), 32'd0);
    chk("reset_wr_dst", 32'(rf_wr_dst), 32'd0);
    chk("reset_busy", 32'(busy_mask), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_issue_stall", 32'(issue_stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;

    // Basic latency-3 write to R5
    drive(1, 0, 0, 1, 5, 3); step(0);
    idle();
    chk("lat3_busy_t1", 32'(busy_mask), 32'h0020); step(0);
    chk("lat3_busy_t2", 32'(busy_mask), 32'h0020); step(0);
    chk("lat3_busy_t3", 32'(busy_mask), 32'h0020); step(0);
    chk("lat3_busy_t4", 32'(busy_mask), 32'h0000);

    // RAW on R5 with latency 2
    drive(1, 0, 0, 1, 5, 2); step(0);
    drive(1, 5, 0, 0, 0, 1); step(1);
`ifdef RF_BYPASS_EN
    #1;
    chk("fwd1_raw", 32'(fwd1), 32'd1);
    chk("fwd2_raw", 32'(fwd2), 32'd0);
    step(0);
`else
    step(1);
    step(0);
`endif
    idle();
    repeat (3) step(0);

    // Port collision, then the retry once the slot has moved on
    drive(1, 0, 0, 1, 3, 3); step(0);
    drive(1, 0, 0, 1, 4, 2); step(1);
    step(0);
    idle();
    repeat (4) step(0);

    // Shorter latency slides in ahead of a pending write
    drive(1, 0, 0, 1, 3, 3); step(0);
    drive(1, 0, 0, 1, 4, 1); step(0);
    idle();
    repeat (4) step(0);
    chk("stall_cnt_mid", 32'(stall_cnt), 32'(expCnt));

    // WAW, src2 RAW, and a non-writing instruction naming a busy dst
    drive(1, 0, 0, 1, 5, 3); step(0);
    drive(1, 0, 0, 1, 5, 1); step(1);
    drive(1, 0, 5, 0, 0, 1); step(1);
    drive(1, 0, 0, 0, 5, 1); step(0);
    idle();
    repeat (3) step(0);

    // R0 never books a slot
    drive(1, 0, 0, 1, 0, 1); step(0);
    chk("r0_busy", 32'(busy_mask), 32'd0);
    drive(1, 0, 0, 0, 0, 3); step(0);
    idle();
    repeat (2) step(0);
    chk("r0_busy_after", 32'(busy_mask), 32'd0);

    // Flush with R7 retiring and R9 pending, plus a dropped same-cycle issue
    drive(1, 0, 0, 1, 7, 3); step(0);
    idle(); step(0);
    drive(1, 0, 0, 1, 9, 3); step(0);
    chk("flush_busy_before", 32'(busy_mask), 32'h0280);
    drive(1, 0, 0, 1, 2, 1);
    flush = 1'b1;
    step(0);
    flush = 1'b0;
    idle();
    chk("flush_busy_after", 32'(busy_mask), 32'd0);
    repeat (4) step(0);
    chk("flush_busy_late", 32'(busy_mask), 32'd0);

    // Asynchronous reset in the middle of traffic
    drive(1, 0, 0, 1, 10, 3); step(0);
    drive(1, 0, 0, 1, 11, 3); step(0);
    idle(); step(0);
    chk("pre_rst_wr_en", 32'(rf_wr_en), 32'd1);
    drive(1, 11, 0, 0, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_wr_en", 32'(rf_wr_en), 32'd0);
    chk("async_wr_dst", 32'(rf_wr_dst), 32'd0);
    chk("async_busy", 32'(busy_mask), 32'd0);
    chk("async_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("async_issue_stall", 32'(issue_stall), 32'd0);
    exp_q.delete();
    expCnt = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc += 10;
    repeat (4) step(0);
    chk("post_rst_busy", 32'(busy_mask), 32'd0);

    // Stall counter saturation
    for (int i = 0; i < 140; i++) begin
      drive(1, 0, 0, 1, 5, 3); step(0);
      drive(1, 5, 0, 0, 0, 1); step(1);
      step(1);
`ifdef RF_BYPASS_EN
      step(0);
`else
      step(1);
`endif
      if (i == 40) chk("stall_cnt_count", 32'(stall_cnt), 32'(expCnt));
    end
    idle();
    repeat (3) step(0);
    chk("stall_cnt_model", 32'(stall_cnt), 32'(expCnt));
    chk("stall_cnt_sat", 32'(stall_cnt), 32'(CNT_MAX));

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
